// File: rtl/shared_bus_arbiter_if.sv
// Shared bus bundle between the requesters/bus sink and the arbiter.
// The master side drives requests, requester data and the sink's ready;
// the slave side (the arbiter) returns grant state and the muxed beat.
interface shared_bus_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               bus_ready;
    logic [NREQ-1:0]    gnt;
    logic [IDW-1:0]     gnt_id;
    logic               busy;
    logic               bus_valid;
    logic [DW-1:0]      bus_data;

    modport master (
        output req, req_data, bus_ready,
        input  gnt, gnt_id, busy, bus_valid, bus_data
    );

    modport slave (
        input  req, req_data, bus_ready,
        output gnt, gnt_id, busy, bus_valid, bus_data
    );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter/sequencer for one shared data bus. One owner at a time
// keeps the bus for at most MAX_BURST completed beats; on release the scan
// starts just after the old owner, so the next owner is granted on the very
// next edge without a dead cycle.
module shared_bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    shared_bus_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    state_e          state_q,    state_d;
    logic [IDW-1:0]  ptr_q,      ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [NREQ-1:0] gnt_q,      gnt_d;
    logic [IDW-1:0]  gnt_id_q,   gnt_id_d;
    logic            busy_q,     busy_d;

    logic            owner_req_s;
    logic            bus_valid_s;
    logic            beat_done_s;
    logic            release_s;
    logic            any_req_s;
    logic [IDW-1:0]  next_ptr_s;
    logic [IDW-1:0]  arb_ptr_s;
    logic [IDW-1:0]  winner_s;
    logic [NREQ-1:0] winner_oh_s;
    logic [DW-1:0]   bus_data_s;

    // First set request bit scanning p, p+1, ... with wrap to 0.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] win;
        logic           found;
        int             idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(p) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Beat completion, release detection and round-robin winner selection.
    always_comb begin
        owner_req_s = bus.req[gnt_id_q];
        bus_valid_s = (state_q == ST_OWN) && owner_req_s;
        beat_done_s = bus_valid_s && bus.bus_ready;
        release_s   = (state_q == ST_OWN) &&
                      (!owner_req_s || (beat_done_s && (beat_cnt_q == LAST_BEAT)));
        if (gnt_id_q == LAST_ID) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gnt_id_q + IDW'(1);
        end
        if (release_s) begin
            arb_ptr_s = next_ptr_s;
        end else begin
            arb_ptr_s = ptr_q;
        end
        any_req_s   = |bus.req;
        winner_s    = rr_pick(bus.req, arb_ptr_s);
        winner_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
    end

    // Next-state logic: grant from IDLE, count beats and hand over in OWN.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d    = ST_OWN;
                    gnt_d      = winner_oh_s;
                    gnt_id_d   = winner_s;
                    busy_d     = 1'b1;
                    beat_cnt_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (release_s) begin
                    ptr_d      = next_ptr_s;
                    beat_cnt_d = '0;
                    if (any_req_s) begin
                        state_d  = ST_OWN;
                        gnt_d    = winner_oh_s;
                        gnt_id_d = winner_s;
                        busy_d   = 1'b1;
                    end else begin
                        // gnt_id deliberately keeps the last owner.
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        busy_d   = 1'b0;
                    end
                end else if (beat_done_s) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                busy_d     = 1'b0;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset drops any burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
        end
    end

    // Bus data mux: owner's slice while owning, zero otherwise.
    always_comb begin
        bus_data_s = '0;
        if (state_q == ST_OWN) begin
            bus_data_s = bus.req_data[int'(gnt_id_q) * DW +: DW];
        end else begin
            bus_data_s = '0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.busy      = busy_q;
    assign bus.bus_valid = bus_valid_s;
    assign bus.bus_data  = bus_data_s;

    // Grant invariants on the registered state.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_busy_match: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (|gnt_q));
    a_owner_bit: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_q[gnt_id_q] == busy_q);
endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (NREQ=4, DW=8, MAX_BURST=4).
// Inputs change on the falling edge; outputs are compared 1 time unit later.
module tb_shared_bus_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    shared_bus_if #(.NREQ(4), .DW(8)) bus ();

    shared_bus_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic       chk;
        logic [3:0] e_gnt;
        logic [1:0] e_id;
        logic       e_busy;
        logic       e_valid;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic rd, input logic c,
                       input logic [3:0] g, input logic [1:0] id, input logic b,
                       input logic v, input logic [7:0] d);
        vec_t t;
        t.rst_n = r; t.req = q; t.rdy = rd; t.chk = c;
        t.e_gnt = g; t.e_id = id; t.e_busy = b; t.e_valid = v; t.e_data = d;
        vecs.push_back(t);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic b, input logic v, input logic [7:0] d);
        check({tag, ".gnt"},       32'(bus.gnt),       32'(g));
        check({tag, ".gnt_id"},    32'(bus.gnt_id),    32'(id));
        check({tag, ".busy"},      32'(bus.busy),      32'(b));
        check({tag, ".bus_valid"}, 32'(bus.bus_valid), 32'(v));
        check({tag, ".bus_data"},  32'(bus.bus_data),  32'(d));
    endtask

    initial begin
        int beats;
        total = 0;
        bad   = 0;
        rst_n         = 1'b0;
        bus.req       = 4'b0000;
        bus.bus_ready = 1'b0;
        bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // rst, req, rdy, chk, gnt, id, busy, valid, data
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00); // 0 reset
        add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00); // 1 reset state
        add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00); // 2 req seen in IDLE
        for (int i = 0; i < 4; i++)
            add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA0); // 3-6 owner 0
        for (int i = 0; i < 4; i++)
            add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 8'hA1); // 7-10 owner 1
        add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2);     // 11 beat 1
        for (int i = 0; i < 3; i++)
            add(1'b1, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2); // 12-14 stall
        for (int i = 0; i < 3; i++)
            add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2); // 15-17 beats 2-4
        for (int i = 0; i < 4; i++)
            add(1'b1, 4'b1101, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 8'hA3); // 18-21 owner 3
        add(1'b1, 4'b0110, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'hA0);     // 22 wrap to 0, drops
        add(1'b1, 4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 8'hA1);     // 23 owner 1 beat
        add(1'b1, 4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 8'hA1);     // 24 owner 1 beat
        add(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 8'hA1);     // 25 owner 1 drops
        add(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2);     // 26 owner 2
        add(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 8'hA2);     // 27 reset mid-burst
        add(1'b1, 4'b1001, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);     // 28 after reset
        add(1'b1, 4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 8'hA0);     // 29 ptr=0 wins
        add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 8'hA0);     // 30 release to idle
        add(1'b1, 4'b1000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);     // 31 idle
        add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 8'hA3);     // 32 owner 3 drops
        add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 8'h00);     // 33 gnt_id holds

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n         = vecs[i].rst_n;
            bus.req       = vecs[i].req;
            bus.bus_ready = vecs[i].rdy;
            #1;
            if (vecs[i].chk)
                check_outs($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_id,
                           vecs[i].e_busy, vecs[i].e_valid, vecs[i].e_data);
        end

        // Lone requester 0: eight back-to-back beats 0x10..0x17, no gap.
        @(negedge clk);
        rst_n = 1'b0; bus.req = 4'b0000; bus.bus_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; bus.req = 4'b0001; bus.req_data[7:0] = 8'h10;
        #1;
        check("solo.latency_gnt", 32'(bus.gnt), 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.req_data[7:0] = 8'h10 + 8'(k);
            #1;
            check($sformatf("solo.gnt%0d", k),   32'(bus.gnt),       32'h1);
            check($sformatf("solo.valid%0d", k), 32'(bus.bus_valid), 32'h1);
            check($sformatf("solo.data%0d", k),  32'(bus.bus_data),  32'(8'h10 + 8'(k)));
        end
        @(negedge clk);
        bus.req = 4'b0000;
        #1;
        check("solo.drop_valid", 32'(bus.bus_valid), 32'h0);
        @(negedge clk);
        #1;
        check("solo.idle_busy", 32'(bus.busy), 32'h0);

        // All four requesting: owners 0,1,2,3,0 with 4 beats each, no idle cycle.
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus.req = 4'b1111;
        beats = 0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rr.owner%0d", k), 32'(bus.gnt_id), 32'((k / 4) % 4));
            check($sformatf("rr.gnt%0d", k),   32'(bus.gnt),    32'(4'b0001 << ((k / 4) % 4)));
            if (k < 16 && bus.bus_valid && bus.bus_ready) beats++;
        end
        check("rr.beats_in_16", 32'(beats), 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
